uart_rx: RTL

//   UART receiver; receive-side counterpart of uart_tx on the PMIC control/debug link.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART frame constants, receiver state encoding and the 2-of-3 vote helper.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_CLOCKS_PER_BIT = 1000;
  localparam int unsigned DATA_BITS              = 8;
  localparam int unsigned IDX_W                  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value selects
// the level the output presents while in reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, start-bit validation, 3-sample majority
// vote per bit, one-cycle valid / framing-error strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rxSerial,
  output logic [DATA_BITS-1:0] o_rxData,
  output logic                 o_rxValid,
  output logic                 o_rxBusy,
  output logic                 o_frameError
);

  localparam int unsigned HALF_BIT = CLOCKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLOCKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_SAMPLE0 = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE1 = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_DECIDE  = CNT_W'(HALF_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 maj_c;

  // Idle-high reset value keeps a released reset from looking like a start edge.
  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rxSerial),
    .o_q     (rx_s)
  );

  // Third sample is the live rx_s at the decision count.
  assign maj_c = majority3(samp_q[0], samp_q[1], rx_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_SAMPLE0) samp_d[0] = rx_s;
      if (cnt_q == CNT_SAMPLE1) samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_W'(1);
        end
      end
      START: begin
        if (cnt_q == CNT_DECIDE && maj_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_DECIDE) shift_d[idx_q] = maj_c;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      // Decide at mid-stop so the next frame's start edge is never missed.
      STOP: begin
        if (cnt_q == CNT_DECIDE) begin
          cnt_d = '0;
          if (maj_c) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_rxData     = data_q;
  assign o_rxValid    = valid_q;
  assign o_rxBusy     = busy_q;
  assign o_frameError = ferr_q;

endmodule
